cs_feeder: RTL

Input staging stage directly upstream of the CS averaging core. It accepts bursty 8-bit samples from a host over a valid/ready handshake and buffers them in a small FIFO. Once a full 9-sample window is buffered, it presents a gap-free stream on `X`, one sample per clock, because the CS core consumes one sample every cycle. It detects starvation of that stream and flags it.

---
 rtl/cs_feeder.sv | 103 ++++++++++
 1 files changed

// File: rtl/cs_feeder.sv
// cs_feeder: input staging FIFO in front of the CS averaging core.
// Buffers bursty host samples, then streams one sample per clock on X once a
// full window is present. A sticky flag records starvation of that stream.
module cs_feeder #(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int START_LEVEL = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    X,
    output logic          x_valid,
    output logic          underrun,
    output logic [AW:0]   level
);

    typedef enum logic {FILL = 1'b0, STREAM = 1'b1} state_t;

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] START_C = (AW + 1)'(START_LEVEL);

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     cnt_q, cnt_d;
    logic [7:0]      x_q, x_d;
    logic            xv_q, xv_d;
    logic            und_q, und_d;
    logic [7:0]      mem [DEPTH];
    logic            push, pop;

    // Full check uses the registered count only, so a same-cycle pop never
    // opens a slot for the push.
    assign in_ready = (cnt_q < DEPTH_C) && !reset;
    assign push     = in_valid && in_ready;

    assign X        = x_q;
    assign x_valid  = xv_q;
    assign underrun = und_q;
    assign level    = cnt_q;

    // State register and all control/output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            x_q      <= 8'h00;
            xv_q     <= 1'b0;
            und_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            xv_q     <= xv_d;
            und_q    <= und_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Sample storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= in_data;
    end

    // Next state: start streaming on a full window, fall back to FILL when dry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (cnt_q >= START_C) state_d = STREAM;
            STREAM:  if (cnt_q == '0)      state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Outputs: pop decision, X/x_valid update, starvation flag, occupancy.
    always_comb begin
        pop   = 1'b0;
        x_d   = x_q;
        xv_d  = 1'b0;
        und_d = und_q;
        case (state_q)
            FILL:    if (cnt_q >= START_C) pop = 1'b1;
            STREAM:  if (cnt_q != '0) pop = 1'b1;
                     else             und_d = 1'b1;
            default: pop = 1'b0;
        endcase
        if (pop) begin
            x_d  = mem[rd_ptr_q];
            xv_d = 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

endmodule
